// File: rtl/mips8_mul_pkg.sv
// rtl/mips8_mul_pkg.sv - shared sizes, FSM states and weighted-term helper for the Booth PP accumulator
package mips8_mul_pkg;

    localparam int NPP = 4;
    localparam int PPW = 9;
    localparam int PW  = 16;
    localparam int IW  = $clog2(NPP);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    // The corrected sign bit, not pp[8], is the extension bit of the 10-bit term.
    function automatic logic [PW-1:0] sext_term(
        input logic           sign,
        input logic [PPW-1:0] pp,
        input logic [IW-1:0]  idx
    );
        logic [PW-1:0] w;
        w = {{(PW-PPW){sign}}, pp};
        return w << {idx, 1'b0};
    endfunction

endpackage

// File: rtl/booth_pp_accumulator.sv
// rtl/booth_pp_accumulator.sv - sequential radix-4 Booth partial-product summer; optional PPACC_EARLY_EXIT_EN
module booth_pp_accumulator #(
    parameter int NPP = mips8_mul_pkg::NPP,
    parameter int PPW = mips8_mul_pkg::PPW,
    parameter int PW  = mips8_mul_pkg::PW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [PPW-1:0] pp0,
    input  logic [PPW-1:0] pp1,
    input  logic [PPW-1:0] pp2,
    input  logic [PPW-1:0] pp3,
    input  logic           sign0,
    input  logic           sign1,
    input  logic           sign2,
    input  logic           sign3,
    output logic           busy,
    output logic           done,
    output logic [PW-1:0]  product
);
    import mips8_mul_pkg::*;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [PW-1:0]   acc;
    logic [PPW-1:0]  pp_q [NPP];
    logic [NPP-1:0]  sign_q;
    logic [PW-1:0]   term;
    logic [PW-1:0]   sum;
    logic            last;

    assign term = sext_term(sign_q[idx], pp_q[idx], idx);
    assign sum  = acc + term;

`ifdef PPACC_EARLY_EXIT_EN
    logic [NPP-1:0] nz;
    logic           rest_zero;

    // Finish on the current add when every later latched term is zero.
    always_comb begin
        nz        = '0;
        rest_zero = 1'b1;
        for (int i = 0; i < NPP; i++) begin
            nz[i] = (|pp_q[i]) | sign_q[i];
        end
        for (int i = 0; i < NPP; i++) begin
            if (i > int'(idx) && nz[i]) begin
                rest_zero = 1'b0;
            end
        end
    end

    assign last = (idx == IW'(NPP-1)) || rest_zero;
`else
    assign last = (idx == IW'(NPP-1));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            acc     <= '0;
            product <= '0;
            sign_q  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            for (int i = 0; i < NPP; i++) begin
                pp_q[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pp_q[0] <= pp0;
                        pp_q[1] <= pp1;
                        pp_q[2] <= pp2;
                        pp_q[3] <= pp3;
                        sign_q  <= {sign3, sign2, sign1, sign0};
                        acc     <= '0;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state   <= ACC;
                    end
                end
                ACC: begin
                    acc <= sum;
                    if (last) begin
                        product <= sum;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
